// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU arbiter: widths, FSM encodings, flag bit positions, requester ids.
// Build option ALU_ARB_RR_EN (round-robin vs fixed priority) is consumed only by rr_arbiter_2.
package alu_arb_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int FLAG_N = 3;
    localparam int FLAG_O = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
        logic              id;
    } operand_t;

    function automatic logic [3:0] pack_flags(input logic n, input logic o,
                                              input logic z, input logic c);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_O] = o;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        return f;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of the two request channels, the ALU side and the response channel.
// slave = arbiter view, master = requesters / ALU / consumer view.
interface alu_arbiter_if;
    import alu_arb_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_ctrl;
    logic [DATA_W-1:0] alu_s;
    logic              alu_n;
    logic              alu_o;
    logic              alu_z;
    logic              alu_c;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_s;
    logic [3:0]        rsp_flags;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_ctrl,
        input  alu_s, alu_n, alu_o, alu_z, alu_c,
        output rsp_valid, rsp_id, rsp_s, rsp_flags,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_ctrl,
        output alu_s, alu_n, alu_o, alu_z, alu_c,
        input  rsp_valid, rsp_id, rsp_s, rsp_flags,
        output rsp_ready
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way one-hot grant. ALU_ARB_RR_EN defined: round-robin against last_grant;
// undefined: requester 0 has fixed priority and last_grant is ignored.
module rr_arbiter_2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
`ifdef ALU_ARB_RR_EN
            grant = last_grant ? 2'b01 : 2'b10;
`else
            grant = 2'b01;
`endif
        end
    end

`ifndef ALU_ARB_RR_EN
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters; operands and results are registered.
// Grant policy selected by ALU_ARB_RR_EN inside rr_arbiter_2.
//
// state | meaning
// IDLE  | waiting for a request; grant and latch operands
// EXEC  | ALU driven from operand registers; capture result and flags
// RESP  | response presented until rsp_ready
module alu_arbiter
    import alu_arb_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    alu_arbiter_if.slave  bus,
    output logic          busy
);

    logic [1:0]        state_q, state_d;
    operand_t          opnd_q, opnd_d;
    logic              last_grant_q, last_grant_d;
    logic [DATA_W-1:0] res_s_q, res_s_d;
    logic [3:0]        res_flags_q, res_flags_d;
    logic              res_id_q, res_id_d;
    logic [1:0]        valid;
    logic [1:0]        grant;

    assign valid = {bus.req1_valid, bus.req0_valid};

    rr_arbiter_2 u_rr_arbiter_2 (
        .valid      (valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        state_d      = state_q;
        opnd_d       = opnd_q;
        last_grant_d = last_grant_q;
        res_s_d      = res_s_q;
        res_flags_d  = res_flags_q;
        res_id_d     = res_id_q;
        case (state_q)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    opnd_d.a     = grant[1] ? bus.req1_a  : bus.req0_a;
                    opnd_d.b     = grant[1] ? bus.req1_b  : bus.req0_b;
                    opnd_d.op    = grant[1] ? bus.req1_op : bus.req0_op;
                    opnd_d.id    = grant[1] ? ID_REQ1 : ID_REQ0;
                    last_grant_d = grant[1] ? ID_REQ1 : ID_REQ0;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_s_d     = bus.alu_s;
                res_flags_d = pack_flags(bus.alu_n, bus.alu_o, bus.alu_z, bus.alu_c);
                res_id_d    = opnd_q.id;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            opnd_q       <= '0;
            last_grant_q <= ID_REQ1;
            res_s_q      <= '0;
            res_flags_q  <= '0;
            res_id_q     <= ID_REQ0;
        end else begin
            state_q      <= state_d;
            opnd_q       <= opnd_d;
            last_grant_q <= last_grant_d;
            res_s_q      <= res_s_d;
            res_flags_q  <= res_flags_d;
            res_id_q     <= res_id_d;
        end
    end

    // Operand registers only change on a grant, so the ALU inputs hold outside EXEC.
    assign bus.alu_a      = opnd_q.a;
    assign bus.alu_b      = opnd_q.b;
    assign bus.alu_ctrl   = opnd_q.op;

    assign bus.req0_ready = (state_q == ST_IDLE) && !RST && grant[0];
    assign bus.req1_ready = (state_q == ST_IDLE) && !RST && grant[1];

    assign bus.rsp_valid  = (state_q == ST_RESP);
    assign bus.rsp_id     = res_id_q;
    assign bus.rsp_s      = res_s_q;
    assign bus.rsp_flags  = res_flags_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small ALU model (add/and/or/xor) on the ALU side.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   n_vec = 0;
    int   n_err = 0;
    logic [8:0] alu_sum;

    alu_arbiter_if bus ();

    alu_arbiter u_dut (
        .CLK  (clk),
        .RST  (rst),
        .bus  (bus.slave),
        .busy (busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        alu_sum = 9'd0;
        case (bus.alu_ctrl)
            3'b000:  alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'b010:  alu_sum = {1'b0, bus.alu_a & bus.alu_b};
            3'b011:  alu_sum = {1'b0, bus.alu_a | bus.alu_b};
            3'b100:  alu_sum = {1'b0, bus.alu_a ^ bus.alu_b};
            default: alu_sum = {1'b0, bus.alu_a};
        endcase
        bus.alu_s = alu_sum[7:0];
        bus.alu_n = alu_sum[7];
        bus.alu_z = (alu_sum[7:0] == 8'h00);
        bus.alu_c = (bus.alu_ctrl == 3'b000) && alu_sum[8];
        bus.alu_o = (bus.alu_ctrl == 3'b000) && (bus.alu_a[7] == bus.alu_b[7])
                    && (alu_sum[7] != bus.alu_a[7]);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic id, input logic v, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] op);
        if (id) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    // Entered in IDLE with rsp_ready high; leaves the DUT back in IDLE.
    task automatic run_op(input string tag, input logic id, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] op,
                          input logic [7:0] exp_s, input logic [3:0] exp_f);
        set_req(id, 1'b1, a, b, op);
        #1;
        chk({tag, "_rdy"}, id ? bus.req1_ready : bus.req0_ready, 1);
        cyc();
        set_req(id, 1'b0, a, b, op);
        cyc();
        #1;
        chk({tag, "_vld"},   bus.rsp_valid, 1);
        chk({tag, "_id"},    bus.rsp_id, id);
        chk({tag, "_s"},     bus.rsp_s, exp_s);
        chk({tag, "_flags"}, bus.rsp_flags, exp_f);
        cyc();
    endtask

    initial begin
        logic exp_id;
        rst = 1'b1;
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 1'b1, 8'h00, 8'h00, 3'b000);
        set_req(1'b1, 1'b1, 8'h00, 8'h00, 3'b000);
        cyc();
        cyc();
        #1;
        chk("rst_rdy0",  bus.req0_ready, 0);
        chk("rst_rdy1",  bus.req1_ready, 0);
        chk("rst_vld",   bus.rsp_valid, 0);
        chk("rst_id",    bus.rsp_id, 0);
        chk("rst_s",     bus.rsp_s, 0);
        chk("rst_flags", bus.rsp_flags, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_alu",   {bus.alu_a, bus.alu_b}, 0);
        chk("rst_ctrl",  bus.alu_ctrl, 0);

        rst = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        cyc();

        // Single request 5 + 3, response held under backpressure.
        set_req(1'b0, 1'b1, 8'h05, 8'h03, 3'b000);
        #1;
        chk("single_rdy0", bus.req0_ready, 1);
        chk("single_rdy1", bus.req1_ready, 0);
        cyc();
        bus.req0_valid = 1'b0;
        #1;
        chk("exec_busy", busy, 1);
        chk("exec_vld",  bus.rsp_valid, 0);
        chk("exec_alu",  {bus.alu_a, bus.alu_b}, 16'h0503);
        chk("exec_ctrl", bus.alu_ctrl, 0);
        cyc();
        #1;
        chk("single_vld",   bus.rsp_valid, 1);
        chk("single_id",    bus.rsp_id, 0);
        chk("single_s",     bus.rsp_s, 8'h08);
        chk("single_flags", bus.rsp_flags, 4'b0000);

        set_req(1'b0, 1'b1, 8'h44, 8'h55, 3'b011);
        set_req(1'b1, 1'b1, 8'h66, 8'h77, 3'b100);
        for (int i = 0; i < 5; i++) begin
            cyc();
            #1;
            chk("bp_vld",  bus.rsp_valid, 1);
            chk("bp_s",    bus.rsp_s, 8'h08);
            chk("bp_id",   bus.rsp_id, 0);
            chk("bp_rdy",  {bus.req1_ready, bus.req0_ready}, 2'b00);
            chk("bp_busy", busy, 1);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        cyc();
        #1;
        chk("bp_idle_busy", busy, 0);
        chk("bp_idle_vld",  bus.rsp_valid, 0);
        chk("hold_alu",     {bus.alu_a, bus.alu_b}, 16'h0503);

        run_op("ovf",  1'b0, 8'h7F, 8'h01, 3'b000, 8'h80, 4'b1100);
        run_op("wrap", 1'b1, 8'hFF, 8'h01, 3'b000, 8'h00, 4'b0011);
        run_op("and",  1'b0, 8'hF0, 8'h0F, 3'b010, 8'h00, 4'b0010);

        // Both requesters valid from reset, rsp_ready high: one grant every 3 cycles.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        set_req(1'b0, 1'b1, 8'h01, 8'h02, 3'b000);
        set_req(1'b1, 1'b1, 8'h10, 8'h20, 3'b000);
        #1;
        for (int g = 0; g < 4; g++) begin
`ifdef ALU_ARB_RR_EN
            exp_id = g[0];
`else
            exp_id = 1'b0;
`endif
            chk("both_rdy", {bus.req1_ready, bus.req0_ready}, exp_id ? 2'b10 : 2'b01);
            cyc();
            cyc();
            #1;
            chk("both_id", bus.rsp_id, exp_id);
            chk("both_s",  bus.rsp_s, exp_id ? 8'h30 : 8'h03);
            cyc();
            #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        // Reset while in EXEC discards the operation.
        set_req(1'b0, 1'b1, 8'h11, 8'h22, 3'b000);
        #1;
        cyc();
        bus.req0_valid = 1'b0;
        #1;
        chk("rexec_busy", busy, 1);
        rst = 1'b1;
        cyc();
        #1;
        chk("rexec_busy0", busy, 0);
        chk("rexec_vld",   bus.rsp_valid, 0);
        chk("rexec_s",     bus.rsp_s, 0);
        chk("rexec_id",    bus.rsp_id, 0);
        chk("rexec_flags", bus.rsp_flags, 0);
        chk("rexec_alu",   {bus.alu_a, bus.alu_b}, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            #1;
            chk("rexec_novld", bus.rsp_valid, 0);
            chk("rexec_idle",  busy, 0);
        end

        // Request readiness must not follow rsp_ready.
        set_req(1'b1, 1'b1, 8'h0A, 8'h0B, 3'b000);
        for (int i = 0; i < 4; i++) begin
            bus.rsp_ready = 1'($urandom_range(0, 1));
            #1;
            chk("indep_rdy", {bus.req1_ready, bus.req0_ready}, 2'b10);
        end
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        cyc();
        #1;
        chk("indep_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
